clock_cmd_sequencer: RTL

Command front-end and event manager for the digital_clock core. It accepts opcode/payload commands over a valid/ready handshake and range-checks them, including the calendar and leap-year rules. Valid commands drive the core's set/alarm/timer inputs and its load strobe. Alarm and timer buzzer pulses from the core are captured as pending events, presented over an acknowledge handshake, and drive a time-limited ring output.

---
 rtl/clock_cmd_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/clock_cmd_sequencer.sv
// clock_cmd_sequencer: command front-end and event manager for the digital_clock core.
// Accepts opcode/payload commands over valid/ready, range-checks them (including
// calendar and leap-year rules), drives the core's set/alarm/timer inputs and load
// strobe, and turns alarm/timer buzzer rises into acknowledged events plus a timed ring.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake and payload
//   cmd_err, core_load                   : one-cycle result pulses
//   set_*, alarm_*, timer_*              : values presented to the core
//   alarm_enable, timer_start            : alarm armed / timer run levels
//   alarm_buzzer, timer_buzzer           : buzzer levels from the core
//   display_mode                         : 0=24h, 1=12h
//   evt_valid/evt_code/evt_ready         : pending event handshake
//   ring                                 : speaker drive
module clock_cmd_sequencer #(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned RING_SECS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [37:0] cmd_data,
    output logic        cmd_err,
    output logic        core_load,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_min,
    output logic [5:0]  set_sec,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [11:0] set_year,
    output logic [4:0]  alarm_hour,
    output logic [5:0]  alarm_min,
    output logic [5:0]  alarm_sec,
    output logic        alarm_enable,
    output logic [5:0]  timer_min,
    output logic [5:0]  timer_sec,
    output logic        timer_start,
    input  logic        alarm_buzzer,
    input  logic        timer_buzzer,
    output logic        display_mode,
    output logic        evt_valid,
    output logic [1:0]  evt_code,
    input  logic        evt_ready,
    output logic        ring
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RING_W = $clog2(RING_SECS + 1);

    typedef enum logic {IDLE, CHECK} state_t;

    typedef struct packed {
        logic [4:0]  hour;
        logic [5:0]  minute;
        logic [5:0]  second;
        logic [4:0]  day;
        logic [3:0]  month;
        logic [11:0] year;
    } payload_t;

    state_t      state, state_n;
    logic [2:0]  op_q, op_n;
    payload_t    data_q, data_n;
    logic        restart_pend, restart_n;
    logic        alarm_prev, timer_prev;
    logic        alarm_pend, alarm_pend_n, timer_pend, timer_pend_n;
    logic [TICK_W-1:0] tick_cnt, tick_n;
    logic [RING_W-1:0] ring_cnt, ring_cnt_n;

    logic        cmd_ready_n, cmd_err_n, core_load_n;
    logic [4:0]  set_hour_n, set_day_n, alarm_hour_n;
    logic [5:0]  set_min_n, set_sec_n, alarm_min_n, alarm_sec_n, timer_min_n, timer_sec_n;
    logic [3:0]  set_month_n;
    logic [11:0] set_year_n;
    logic        alarm_enable_n, timer_start_n, display_mode_n;
    logic        evt_valid_n, ring_n;
    logic [1:0]  evt_code_n;

    logic        accept, alarm_rise, timer_rise, sec_tick;
    logic        leap, time_ok, date_ok, cmd_ok;
    logic [4:0]  dim;

    assign accept     = cmd_valid & cmd_ready;
    assign alarm_rise = alarm_buzzer & ~alarm_prev;
    assign timer_rise = timer_buzzer & ~timer_prev;
    assign sec_tick   = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Range check of the captured command, including days-in-month with leap years.
    always_comb begin : validity
        leap = ((data_q.year[1:0] == 2'd0) && ((data_q.year % 12'd100) != 12'd0))
             || ((data_q.year % 12'd400) == 12'd0);
        case (data_q.month)
            4'd2:                      dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
        time_ok = (data_q.hour <= 5'd23) && (data_q.minute <= 6'd59) && (data_q.second <= 6'd59);
        date_ok = (data_q.month >= 4'd1) && (data_q.month <= 4'd12)
               && (data_q.day >= 5'd1) && (data_q.day <= dim);
        case (op_q)
            3'd0:    cmd_ok = 1'b0;
            3'd3:    cmd_ok = time_ok && date_ok;
            3'd4:    cmd_ok = time_ok;
            3'd5:    cmd_ok = (data_q.minute <= 6'd59) && (data_q.second <= 6'd59)
                           && ((data_q.minute | data_q.second) != 6'd0);
            default: cmd_ok = 1'b1;
        endcase
    end

    // Command FSM next-state and command-driven outputs.
    always_comb begin : next_logic
        state_n        = state;
        op_n           = op_q;
        data_n         = data_q;
        cmd_ready_n    = (state == IDLE) && !accept;
        cmd_err_n      = 1'b0;
        core_load_n    = 1'b0;
        restart_n      = 1'b0;
        set_hour_n     = set_hour;
        set_min_n      = set_min;
        set_sec_n      = set_sec;
        set_day_n      = set_day;
        set_month_n    = set_month;
        set_year_n     = set_year;
        alarm_hour_n   = alarm_hour;
        alarm_min_n    = alarm_min;
        alarm_sec_n    = alarm_sec;
        alarm_enable_n = alarm_enable;
        timer_min_n    = timer_min;
        timer_sec_n    = timer_sec;
        timer_start_n  = timer_start;
        display_mode_n = display_mode;

        // Buzzer rises disarm; a command applied in the same cycle overrides below.
        if (alarm_rise)   alarm_enable_n = 1'b0;
        if (timer_rise)   timer_start_n  = 1'b0;
        // Second half of a timer restart: run again one cycle after the preset load.
        if (restart_pend) timer_start_n  = 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = CHECK;
                    op_n    = cmd_op;
                    data_n  = payload_t'(cmd_data);
                end
            end
            CHECK: begin
                state_n = IDLE;
                if (!cmd_ok) begin
                    cmd_err_n = 1'b1;
                end else begin
                    case (op_q)
                        3'd1: display_mode_n = 1'b1;
                        3'd2: display_mode_n = 1'b0;
                        3'd3: begin
                            set_hour_n  = data_q.hour;
                            set_min_n   = data_q.minute;
                            set_sec_n   = data_q.second;
                            set_day_n   = data_q.day;
                            set_month_n = data_q.month;
                            set_year_n  = data_q.year;
                            core_load_n = 1'b1;
                        end
                        3'd4: begin
                            alarm_hour_n   = data_q.hour;
                            alarm_min_n    = data_q.minute;
                            alarm_sec_n    = data_q.second;
                            alarm_enable_n = 1'b1;
                        end
                        3'd5: begin
                            timer_min_n   = data_q.minute;
                            timer_sec_n   = data_q.second;
                            timer_start_n = 1'b0;
                            restart_n     = 1'b1;
                        end
                        3'd6:    alarm_enable_n = 1'b0;
                        3'd7:    timer_start_n  = 1'b0;
                        default: ;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pending events, acknowledge, seconds tick and ring timer.
    always_comb begin : event_logic
        alarm_pend_n = (alarm_pend & ~(evt_valid & evt_ready & (evt_code == 2'b01))) | alarm_rise;
        timer_pend_n = (timer_pend & ~(evt_valid & evt_ready & (evt_code == 2'b10))) | timer_rise;
        evt_valid_n  = alarm_pend_n | timer_pend_n;
        evt_code_n   = alarm_pend_n ? 2'b01 : 2'b10;

        tick_n = sec_tick ? TICK_W'(0) : tick_cnt + TICK_W'(1);

        ring_cnt_n = ring_cnt;
        if (alarm_rise || timer_rise) begin
            ring_cnt_n = RING_W'(RING_SECS);
        end else if (sec_tick && (ring_cnt != RING_W'(0))) begin
            ring_cnt_n = ring_cnt - RING_W'(1);
        end
        ring_n = (ring_cnt_n != RING_W'(0));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            op_q         <= 3'd0;
            data_q       <= '0;
            restart_pend <= 1'b0;
            alarm_prev   <= 1'b0;
            timer_prev   <= 1'b0;
            alarm_pend   <= 1'b0;
            timer_pend   <= 1'b0;
            tick_cnt     <= '0;
            ring_cnt     <= '0;
            cmd_ready    <= 1'b1;
            cmd_err      <= 1'b0;
            core_load    <= 1'b0;
            set_hour     <= 5'd0;
            set_min      <= 6'd0;
            set_sec      <= 6'd0;
            set_day      <= 5'd1;
            set_month    <= 4'd1;
            set_year     <= 12'd2020;
            alarm_hour   <= 5'd0;
            alarm_min    <= 6'd0;
            alarm_sec    <= 6'd0;
            alarm_enable <= 1'b0;
            timer_min    <= 6'd0;
            timer_sec    <= 6'd0;
            timer_start  <= 1'b0;
            display_mode <= 1'b0;
            evt_valid    <= 1'b0;
            evt_code     <= 2'b10;
            ring         <= 1'b0;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            data_q       <= data_n;
            restart_pend <= restart_n;
            alarm_prev   <= alarm_buzzer;
            timer_prev   <= timer_buzzer;
            alarm_pend   <= alarm_pend_n;
            timer_pend   <= timer_pend_n;
            tick_cnt     <= tick_n;
            ring_cnt     <= ring_cnt_n;
            cmd_ready    <= cmd_ready_n;
            cmd_err      <= cmd_err_n;
            core_load    <= core_load_n;
            set_hour     <= set_hour_n;
            set_min      <= set_min_n;
            set_sec      <= set_sec_n;
            set_day      <= set_day_n;
            set_month    <= set_month_n;
            set_year     <= set_year_n;
            alarm_hour   <= alarm_hour_n;
            alarm_min    <= alarm_min_n;
            alarm_sec    <= alarm_sec_n;
            alarm_enable <= alarm_enable_n;
            timer_min    <= timer_min_n;
            timer_sec    <= timer_sec_n;
            timer_start  <= timer_start_n;
            display_mode <= display_mode_n;
            evt_valid    <= evt_valid_n;
            evt_code     <= evt_code_n;
            ring         <= ring_n;
        end
    end

endmodule
